instruction_memory: RTL and testbench
=====================================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 The block SHALL have the following ports, one clock domain:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset, sampled on rising clk.
- instruction_address  input  10  word address driven by the program counter.
- fetch_req  input  1  fetch strobe; the address is sampled when this is high.
- load_en  input  1  program-load write strobe.
- load_addr  input  10  write word address.
- load_data  input  32  write data.
- load_done  input  1  end-of-load pulse.
- instruction  output  32  fetched instruction word.
- instr_valid  output  1  instruction is valid this cycle.
- fetch_error  output  1  one-cycle pulse: fetch was rejected.
- ready  output  1  high in state READY.
- fetch_count  output  16  accepted fetches; present only with FETCH_COUNT_EN.

Function
REQ-002 Storage SHALL be 1024 x 32-bit words, one word per instruction_address value; no byte addressing.
REQ-003 The FSM SHALL have three states: BOOT, LOAD and READY.
REQ-004 BOOT -> LOAD SHALL occur when load_en=1.
REQ-005 LOAD -> READY SHALL occur when load_done=1.
REQ-006 READY -> LOAD SHALL occur when load_en=1; this is a reload.
REQ-007 All other conditions SHALL hold the current state.
REQ-008 In BOOT, load_done without load_en SHALL be ignored.
REQ-009 A write SHALL occur on every clk with load_en=1 in BOOT or LOAD: mem[load_addr] <= load_data.
REQ-010 In READY, a write happens only on the transition cycle, because load_en is high on that cycle.
REQ-011 If load_en and load_done are both 1 in LOAD, the write SHALL complete and the FSM SHALL move to READY. The written word is readable from the next cycle.
REQ-012 Accepted fetch: fetch_req=1 in READY with load_en=0.
- Read latency SHALL be exactly one cycle.
- Address sampled at edge N -> instruction=mem[addr] and instr_valid=1 after edge N+1.
REQ-013 Back-to-back fetches SHALL be supported at one per cycle with no bubbles.
REQ-014 instr_valid SHALL be 0 in any cycle following a non-accepted edge.
- instruction SHALL hold its last value while instr_valid=0.
REQ-015 Rejected fetch: fetch_req=1 in BOOT or LOAD, or in READY with load_en=1 (load wins).
- fetch_error SHALL pulse for one cycle after the edge.
- instr_valid SHALL be 0 and no read occurs.
REQ-016 All 10-bit address values, including 10'h3FF, SHALL be legal. No wrap logic; the program counter owns wrap.
REQ-017 Read and write of the same address on the same edge cannot occur, because load and fetch are mutually exclusive per REQ-015.
REQ-018 All outputs SHALL be registered; there are no combinational input-to-output paths.

Reset
REQ-019 On reset=1 at a rising edge, the following SHALL apply:
- state=BOOT, ready=0, instr_valid=0, fetch_error=0, instruction=32'h0000_0013 (NOP), fetch_count=0.
REQ-020 Reset SHALL NOT clear memory contents.
REQ-021 Reset SHALL override load_en, load_done and fetch_req on the same edge. No write or read occurs on a reset edge.
REQ-022 Reset mid-LOAD SHALL return the FSM to BOOT. Words already written SHALL persist.

Configuration
REQ-023 Macro FETCH_COUNT_EN, when defined:
- The fetch_count port SHALL exist.
- It increments by 1 on every accepted fetch and saturates at 16'hFFFF; it does not wrap.
- Rejected fetches do not count.
- It clears only on reset.
REQ-024 Without FETCH_COUNT_EN, the port and the counter logic SHALL be absent. All other behaviour is identical.

Verification
REQ-025 Reset then fetch: reset 1 cycle, then fetch_req=1 with addr=0 -> instr_valid=0, fetch_error=1 for one cycle, ready=0, instruction=32'h0000_0013.
REQ-026 Load then stream:
- Stimulus: write mem[i]=32'hA000_0000+i for i=0..7, pulse load_done, then fetch addr 0..7 on consecutive cycles.
- Response: ready=1; instruction=32'hA000_0000..32'hA000_0007, each one cycle after its address; instr_valid continuously 1.
REQ-027 Boundary address: load mem[10'h3FF]=32'hDEAD_BEEF, load_done, fetch 10'h3FF -> instruction=32'hDEAD_BEEF next cycle.
REQ-028 Collision in READY: load_en=1 (addr 5, data 32'h1234_5678) with fetch_req=1 (addr 5) on the same edge.
- Response: fetch_error=1, instr_valid=0, ready=0 next cycle.
- After load_done, fetch addr 5 -> 32'h1234_5678.
REQ-029 Reset mid-load: write 3 words, assert reset, reload 0 words, load_done, fetch addr 1 -> original word returned; fetch_count=1 when FETCH_COUNT_EN is defined.
REQ-030 Counter saturation, with FETCH_COUNT_EN: 65540 accepted fetches -> fetch_count=16'hFFFF. Rejected fetches leave the count unchanged.

Source files
------------

// File: rtl/instruction_memory.sv
// 1024 x 32 instruction store with a BOOT/LOAD/READY load sequencer and a one-cycle registered fetch port.
// Optional accepted-fetch counter, enabled by defining FETCH_COUNT_EN.
module instruction_memory (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  instruction_address,
   input  logic        fetch_req,
   input  logic        load_en,
   input  logic [9:0]  load_addr,
   input  logic [31:0] load_data,
   input  logic        load_done,
   output logic [31:0] instruction,
   output logic        instr_valid,
   output logic        fetch_error,
   output logic        ready
`ifdef FETCH_COUNT_EN
   ,
   output logic [15:0] fetch_count
`endif
);

   // state | meaning
   // BOOT  | after reset, waiting for the first load write
   // LOAD  | program words being written, waiting for load_done
   // READY | program loaded, fetches accepted
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state;
   state_t      next_state;
   logic        accept;
   logic [31:0] mem [1024];

   // A load strobe always wins over a fetch, so a read and a write never meet on one edge.
   assign accept = fetch_req && (state == READY) && !load_en;

   always_comb begin
      next_state = state;
      case (state)
         BOOT:    if (load_en)   next_state = LOAD;
         LOAD:    if (load_done) next_state = READY;
         READY:   if (load_en)   next_state = LOAD;
         default: next_state = BOOT;
      endcase
   end

   // Memory is deliberately not reset; only the write strobe is gated by reset.
   always_ff @(posedge clk) begin
      if (!reset && load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= BOOT;
         ready       <= 1'b0;
         instr_valid <= 1'b0;
         fetch_error <= 1'b0;
         instruction <= NOP;
      end else begin
         state       <= next_state;
         ready       <= (next_state == READY);
         instr_valid <= accept;
         fetch_error <= fetch_req && !accept;
         if (accept) begin
            instruction <= mem[instruction_address];
         end
      end
   end

`ifdef FETCH_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count <= 16'h0000;
      end else if (accept && (fetch_count != 16'hFFFF)) begin
         fetch_count <= fetch_count + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// Directed and randomized bench for instruction_memory, checked against an array/mode reference model.
// Build with FETCH_COUNT_EN defined to also exercise the fetch counter.
module tb_instruction_memory;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  instruction_address;
   logic        fetch_req;
   logic        load_en;
   logic [9:0]  load_addr;
   logic [31:0] load_data;
   logic        load_done;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        fetch_error;
   logic        ready;
`ifdef FETCH_COUNT_EN
   logic [15:0] fetch_count;
`endif

   instruction_memory dut (
      .clk                 (clk),
      .reset               (reset),
      .instruction_address (instruction_address),
      .fetch_req           (fetch_req),
      .load_en             (load_en),
      .load_addr           (load_addr),
      .load_data           (load_data),
      .load_done           (load_done),
      .instruction         (instruction),
      .instr_valid         (instr_valid),
      .fetch_error         (fetch_error),
      .ready               (ready)
`ifdef FETCH_COUNT_EN
      ,
      .fetch_count         (fetch_count)
`endif
   );

   always #5 clk = ~clk;

   localparam int M_BOOT  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_READY = 2;

   int          passed = 0;
   int          total  = 0;

   logic [31:0] m_mem [1024];
   bit          m_written [1024];
   int          m_mode;
   logic [31:0] m_instr;
   bit          m_instr_known;
   bit          m_valid;
   bit          m_err;
   int          m_count;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One clock edge with the given inputs; the model advances and every output is compared.
   task automatic step(input bit rst, input bit le, input logic [9:0] la, input logic [31:0] ld,
                       input bit done, input bit fr, input logic [9:0] fa);
      bit acc;
      reset = rst; load_en = le; load_addr = la; load_data = ld;
      load_done = done; fetch_req = fr; instruction_address = fa;
      @(posedge clk);
      #1;
      if (rst) begin
         m_mode = M_BOOT; m_valid = 0; m_err = 0;
         m_instr = 32'h0000_0013; m_instr_known = 1; m_count = 0;
      end else begin
         acc     = fr && (m_mode == M_READY) && !le;
         m_valid = acc;
         m_err   = fr && !acc;
         if (acc) begin
            m_instr       = m_mem[fa];
            m_instr_known = m_written[fa];
            if (m_count < 65535) m_count++;
         end
         if (le) begin
            m_mem[la]     = ld;
            m_written[la] = 1;
         end
         if (m_mode == M_BOOT && le)        m_mode = M_LOAD;
         else if (m_mode == M_LOAD && done) m_mode = M_READY;
         else if (m_mode == M_READY && le)  m_mode = M_LOAD;
      end
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("fetch_error", {31'b0, fetch_error}, {31'b0, m_err});
      chk("ready",       {31'b0, ready},       {31'b0, (m_mode == M_READY)});
      if (m_instr_known) chk("instruction", instruction, m_instr);
`ifdef FETCH_COUNT_EN
      chk("fetch_count", {16'b0, fetch_count}, m_count[31:0]);
`endif
   endtask

   task automatic idle();
      step(0, 0, 10'd0, 32'd0, 0, 0, 10'd0);
   endtask

   task automatic fetch(input logic [9:0] a);
      step(0, 0, 10'd0, 32'd0, 0, 1, a);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         m_mem[i] = 32'h0; m_written[i] = 0;
      end
      m_mode = M_BOOT; m_instr = 32'h0000_0013; m_instr_known = 0;
      m_valid = 0; m_err = 0; m_count = 0;

      // Reset then fetch in BOOT: rejected, NOP held.
      step(1, 0, 10'd0, 32'd0, 0, 0, 10'd0);
      chk("reset_instr", instruction, 32'h0000_0013);
      chk("reset_ready", {31'b0, ready}, 32'd0);
      fetch(10'd0);
      chk("boot_fetch_err", {31'b0, fetch_error}, 32'd1);
      chk("boot_fetch_instr", instruction, 32'h0000_0013);
      idle();
      chk("err_one_cycle", {31'b0, fetch_error}, 32'd0);

      // load_done alone in BOOT is ignored.
      step(0, 0, 10'd0, 32'd0, 1, 0, 10'd0);
      chk("boot_done_ignored", {31'b0, ready}, 32'd0);

      // Load 0..7, load_done, stream 0..7.
      for (int i = 0; i < 8; i++) step(0, 1, i[9:0], 32'hA000_0000 + i, 0, 0, 10'd0);
      step(0, 0, 10'd0, 32'd0, 1, 0, 10'd0);
      chk("loaded_ready", {31'b0, ready}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         fetch(i[9:0]);
         chk("stream_instr", instruction, 32'hA000_0000 + i);
         chk("stream_valid", {31'b0, instr_valid}, 32'd1);
      end
      idle();
      chk("valid_drops", {31'b0, instr_valid}, 32'd0);
      chk("instr_holds", instruction, 32'hA000_0007);

      // Top address, with write and load_done on the same edge.
      step(0, 1, 10'h3FF, 32'hDEAD_BEEF, 0, 0, 10'd0);
      step(0, 1, 10'h3FE, 32'h0BAD_F00D, 1, 0, 10'd0);
      chk("done_with_write_ready", {31'b0, ready}, 32'd1);
      fetch(10'h3FF);
      chk("top_addr", instruction, 32'hDEAD_BEEF);
      fetch(10'h3FE);
      chk("write_on_done_edge", instruction, 32'h0BAD_F00D);

      // Collision in READY: load wins.
      step(0, 1, 10'd5, 32'h1234_5678, 0, 1, 10'd5);
      chk("collide_err", {31'b0, fetch_error}, 32'd1);
      chk("collide_valid", {31'b0, instr_valid}, 32'd0);
      chk("collide_ready", {31'b0, ready}, 32'd0);
      step(0, 0, 10'd0, 32'd0, 1, 0, 10'd0);
      fetch(10'd5);
      chk("collide_data", instruction, 32'h1234_5678);

      // Reset mid-load: earlier words persist.
      step(0, 1, 10'd1, 32'h5555_0001, 0, 0, 10'd0);
      step(0, 1, 10'd2, 32'h5555_0002, 0, 0, 10'd0);
      step(0, 1, 10'd3, 32'h5555_0003, 0, 0, 10'd0);
      step(1, 1, 10'd1, 32'hFFFF_FFFF, 1, 1, 10'd1);
      chk("rst_override_ready", {31'b0, ready}, 32'd0);
      step(0, 1, 10'd200, 32'h7777_7777, 0, 0, 10'd0);
      step(0, 0, 10'd0, 32'd0, 1, 0, 10'd0);
      fetch(10'd1);
      chk("persist_after_reset", instruction, 32'h5555_0001);
`ifdef FETCH_COUNT_EN
      chk("count_after_reset", {16'b0, fetch_count}, 32'd1);
`endif

      // Randomized traffic over a preloaded window.
      for (int i = 0; i < 32; i++) step(0, 1, i[9:0], $urandom, 0, 0, 10'd0);
      step(0, 0, 10'd0, 32'd0, 1, 0, 10'd0);
      for (int i = 0; i < 1500; i++) begin
         int r;
         r = $urandom_range(0, 99);
         step(($urandom_range(0, 199) == 0), (r < 10), 10'($urandom_range(0, 31)), $urandom,
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7), 10'($urandom_range(0, 31)));
      end

`ifdef FETCH_COUNT_EN
      step(1, 0, 10'd0, 32'd0, 0, 0, 10'd0);
      step(0, 1, 10'd9, 32'h0000_0009, 1, 0, 10'd0);
      step(0, 0, 10'd0, 32'd0, 1, 0, 10'd0);
      for (int i = 0; i < 65540; i++) fetch(10'd9);
      chk("count_saturated", {16'b0, fetch_count}, 32'h0000_FFFF);
      step(0, 1, 10'd9, 32'h0000_0009, 0, 1, 10'd9);
      fetch(10'd9);
      chk("count_sat_after_reject", {16'b0, fetch_count}, 32'h0000_FFFF);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
